// File: rtl/fifo_burst_arbiter_if.sv
// Handshake bundle between the two requesters, the burst arbiter and the
// FIFO controller strobes it drives.
interface fifo_burst_arbiter_if #(
    parameter int DEPTH = 8,
    parameter int LW    = 3
);
    localparam int OW = $clog2(DEPTH + 1);

    logic [1:0]    req;
    logic [1:0]    op;
    logic [LW-1:0] len0;
    logic [LW-1:0] len1;
    logic [1:0]    gnt;
    logic [1:0]    done;
    logic          fifo_sw;
    logic          fifo_en;
    logic [OW-1:0] occ;
    logic          busy;

    modport slave (
        input  req, op, len0, len1,
        output gnt, done, fifo_sw, fifo_en, occ, busy
    );

    modport master (
        output req, op, len0, len1,
        input  gnt, done, fifo_sw, fifo_en, occ, busy
    );
endinterface

// File: rtl/fifo_burst_arbiter.sv
// Round-robin burst arbiter in front of a DEPTH-entry FIFO controller.
// Only whole bursts that fit the tracked occupancy are granted; a one-cycle
// GAP separates bursts so the controller idles before a direction change.

// Per-requester eligibility: the whole burst must fit the current occupancy.
module fba_elig #(
    parameter int DEPTH = 8,
    parameter int LW    = 3,
    parameter int OW    = 4,
    parameter int EW    = 5
) (
    input  logic          req,
    input  logic          op,
    input  logic [LW-1:0] len,
    input  logic [OW-1:0] occ,
    output logic          elig
);
    logic [EW-1:0] beats;
    logic [EW-1:0] occ_x;

    // Widened compare so occ + beats never wraps.
    always_comb begin
        beats = EW'(len) + EW'(1);
        occ_x = EW'(occ);
        elig  = 1'b0;
        if (req)
            elig = op ? ((occ_x + beats) <= EW'(DEPTH)) : (beats <= occ_x);
    end
endmodule

module fifo_burst_arbiter #(
    parameter int DEPTH = 8,
    parameter int LW    = 3
) (
    input  logic                 clock,
    input  logic                 rst,
    fifo_burst_arbiter_if.slave  bus
);
    localparam int OW = $clog2(DEPTH + 1);
    localparam int CW = LW + 1;
    localparam int EW = ((OW > CW) ? OW : CW) + 1;

    typedef enum logic [1:0] {IDLE, BURST, GAP} state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;       // beats left, including the current one
    logic          dir, dir_n;       // latched direction, 1 = write
    logic          who, who_n;       // requester owning the burst
    logic          last, last_n;     // last granted requester
    logic [OW-1:0] occ, occ_n;

    logic [1:0] gnt_n, done_n;
    logic       en_n, sw_n, busy_n;

    logic [1:0][LW-1:0] lens;
    logic [1:0]         elig;
    logic               win;

    assign lens    = {bus.len1, bus.len0};
    assign bus.occ = occ;

    generate
        for (genvar i = 0; i < 2; i++) begin : g_elig
            fba_elig #(.DEPTH(DEPTH), .LW(LW), .OW(OW), .EW(EW)) u_elig (
                .req  (bus.req[i]),
                .op   (bus.op[i]),
                .len  (lens[i]),
                .occ  (occ),
                .elig (elig[i])
            );
        end
    endgenerate

    // On a tie the requester not granted last wins; otherwise the only eligible one.
    always_comb begin
        win = (elig == 2'b11) ? ~last : elig[1];
    end

    // Next-state, burst bookkeeping and next registered outputs.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        dir_n   = dir;
        who_n   = who;
        last_n  = last;
        occ_n   = occ;
        done_n  = 2'b00;
        case (state)
            IDLE, GAP: begin
                if (|elig) begin
                    state_n = BURST;
                    who_n   = win;
                    last_n  = win;
                    dir_n   = bus.op[win];
                    cnt_n   = CW'(lens[win]) + CW'(1);
                end else begin
                    state_n = IDLE;
                end
            end
            BURST: begin
                occ_n = dir ? occ + OW'(1) : occ - OW'(1);
                cnt_n = cnt - CW'(1);
                if (cnt == CW'(1)) begin
                    state_n = GAP;
                    done_n  = who ? 2'b10 : 2'b01;
                end
            end
            default: state_n = IDLE;
        endcase
        busy_n = (state_n == BURST);
        en_n   = busy_n;
        sw_n   = busy_n & dir_n;
        gnt_n  = busy_n ? (who_n ? 2'b10 : 2'b01) : 2'b00;
    end

    // State and registered outputs; reset parks everything with requester 0 favoured.
    always_ff @(posedge clock) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            dir         <= 1'b0;
            who         <= 1'b0;
            last        <= 1'b1;
            occ         <= '0;
            bus.gnt     <= 2'b00;
            bus.done    <= 2'b00;
            bus.fifo_en <= 1'b0;
            bus.fifo_sw <= 1'b0;
            bus.busy    <= 1'b0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            dir         <= dir_n;
            who         <= who_n;
            last        <= last_n;
            occ         <= occ_n;
            bus.gnt     <= gnt_n;
            bus.done    <= done_n;
            bus.fifo_en <= en_n;
            bus.fifo_sw <= sw_n;
            bus.busy    <= busy_n;
        end
    end
endmodule
